// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: the state type, the field widths and the load-use rule.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } hz_state_e;

  function automatic logic load_use_hazard(
    input logic             ex_mem_rd,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt,
    input logic             id_uses_rt
  );
    return ex_mem_rd && (ex_rt != '0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle. The master is the pipeline, and the slave is hazard_ctrl.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REG_W-1:0] ID_rs;
  logic [REG_W-1:0] ID_rt;
  logic             ID_uses_rt;
  logic [REG_W-1:0] EX_rt;
  logic             EX_Mem_rd;
  logic             EX_Branch_taken;
  logic             ID_Jump;
  logic             MEM_busy;

  logic             PC_stall;
  logic             IF_ID_stall;
  logic             ID_EX_stall;
  logic             EX_MEM_stall;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_timeout;

  modport master (
    output ID_rs, ID_rt, ID_uses_rt, EX_rt, EX_Mem_rd, EX_Branch_taken, ID_Jump, MEM_busy,
    input  PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush, ID_EX_flush,
    input  stall_cnt, flush_cnt, mem_timeout
  );

  modport slave (
    input  ID_rs, ID_rt, ID_uses_rt, EX_rt, EX_Mem_rd, EX_Branch_taken, ID_Jump, MEM_busy,
    output PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush, ID_EX_flush,
    output stall_cnt, flush_cnt, mem_timeout
  );

endinterface

// File: rtl/hazard_sat_cnt.sv
// Event counter that counts up by one when enabled and holds at all-ones instead of wrapping.
module hazard_sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller. It produces combinational stall and flush controls, uses a memory-wait FSM
// with a watchdog, and keeps saturating event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam logic [WAIT_W-1:0] LP_WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e         r_state;
  hz_state_e         w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;
  logic              w_fire;
  logic              w_load_use;
  logic              w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall;
  logic              w_ifid_flush, w_idex_flush;
  logic [CNT_W-1:0]  w_stall_cnt, w_flush_cnt;

  assign w_load_use = load_use_hazard(hz.EX_Mem_rd, hz.EX_rt, hz.ID_rs, hz.ID_rt, hz.ID_uses_rt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_fire = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (hz.MEM_busy) w_next = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (!hz.MEM_busy) begin
          w_next = ST_RUN;
        end else if (r_wait_cnt == LP_WAIT_LAST) begin
          w_next = ST_RUN;
          w_fire = 1'b1;
        end
      end
      default: w_next = ST_RUN;
    endcase
  end

  // Outputs are gated by reset so that the pipeline sees no stall or flush while the controller is held in reset.
  always_comb begin
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_idex_stall  = 1'b0;
    w_exmem_stall = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    if (reset) begin
      if ((r_state == ST_MEM_WAIT) || hz.MEM_busy) begin
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_stall  = 1'b1;
        w_exmem_stall = 1'b1;
      end else if (hz.EX_Branch_taken) begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
      end else if (w_load_use) begin
        w_pc_stall   = 1'b1;
        w_ifid_stall = 1'b1;
        w_idex_flush = 1'b1;
      end else if (hz.ID_Jump) begin
        w_ifid_flush = 1'b1;
      end
    end
  end

  // Holding the counter at zero throughout RUN guarantees that it starts from zero on every entry to MEM_WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout <= 1'b0;
    end else if (w_fire) begin
      r_timeout <= 1'b1;
    end
  end

  hazard_sat_cnt #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_pc_stall),
    .o_cnt (w_stall_cnt)
  );

  hazard_sat_cnt #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_ifid_flush | w_idex_flush),
    .o_cnt (w_flush_cnt)
  );

  assign hz.PC_stall     = w_pc_stall;
  assign hz.IF_ID_stall  = w_ifid_stall;
  assign hz.ID_EX_stall  = w_idex_stall;
  assign hz.EX_MEM_stall = w_exmem_stall;
  assign hz.IF_ID_flush  = w_ifid_flush;
  assign hz.ID_EX_flush  = w_idex_flush;
  assign hz.stall_cnt    = w_stall_cnt;
  assign hz.flush_cnt    = w_flush_cnt;
  assign hz.mem_timeout  = r_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed steps and random traffic, checked against a rule-level reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: whether memory wait is in progress, its length so far, the sticky flag, and event totals.
  bit          m_waiting;
  int unsigned m_wait_len;
  bit          m_tmo;
  int unsigned m_stall;
  int unsigned m_flush;

  // Control vector order: {PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush, ID_EX_flush}
  function automatic logic [5:0] model_ctl();
    bit lu;
    if (!reset) return 6'b000000;
    if (m_waiting || hz.MEM_busy) return 6'b111100;
    if (hz.EX_Branch_taken) return 6'b000011;
    lu = hz.EX_Mem_rd && (hz.EX_rt != 0) &&
         ((hz.EX_rt == hz.ID_rs) || (hz.ID_uses_rt && (hz.EX_rt == hz.ID_rt)));
    if (lu) return 6'b110001;
    if (hz.ID_Jump) return 6'b000010;
    return 6'b000000;
  endfunction

  function automatic logic [5:0] dut_ctl();
    return {hz.PC_stall, hz.IF_ID_stall, hz.ID_EX_stall, hz.EX_MEM_stall,
            hz.IF_ID_flush, hz.ID_EX_flush};
  endfunction

  task automatic model_reset();
    m_waiting  = 1'b0;
    m_wait_len = 0;
    m_tmo      = 1'b0;
    m_stall    = 0;
    m_flush    = 0;
  endtask

  task automatic model_edge(input logic [5:0] e);
    if (!reset) return;
    if (e[5] && (m_stall < 32'd65535)) m_stall++;
    if ((e[1] || e[0]) && (m_flush < 32'd65535)) m_flush++;
    if (m_waiting) begin
      m_wait_len++;
      if (!hz.MEM_busy) begin
        m_waiting = 1'b0;
      end else if (m_wait_len == TMO) begin
        m_waiting = 1'b0;
        m_tmo     = 1'b1;
      end
    end else if (hz.MEM_busy) begin
      m_waiting  = 1'b1;
      m_wait_len = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.ID_rs           = '0;
    hz.ID_rt           = '0;
    hz.ID_uses_rt      = 1'b0;
    hz.EX_rt           = '0;
    hz.EX_Mem_rd       = 1'b0;
    hz.EX_Branch_taken = 1'b0;
    hz.ID_Jump         = 1'b0;
    hz.MEM_busy        = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied. Returns at the next falling edge.
  task automatic step(input string tag);
    logic [5:0] e;
    #1;
    e = model_ctl();
    chk({tag, ".ctl"},       32'(dut_ctl()),      32'(e));
    chk({tag, ".stall_cnt"}, 32'(hz.stall_cnt),   m_stall);
    chk({tag, ".flush_cnt"}, 32'(hz.flush_cnt),   m_flush);
    chk({tag, ".timeout"},   32'(hz.mem_timeout), 32'(m_tmo));
    @(posedge clk);
    model_edge(e);
    @(negedge clk);
  endtask

  int unsigned s0;
  int unsigned f0;

  initial begin
    reset = 1'b0;
    clear_inputs();
    hz.MEM_busy        = 1'b1;
    hz.EX_Branch_taken = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst.ctl",       32'(dut_ctl()),      32'd0);
    chk("rst.stall_cnt", 32'(hz.stall_cnt),   32'd0);
    chk("rst.flush_cnt", 32'(hz.flush_cnt),   32'd0);
    chk("rst.timeout",   32'(hz.mem_timeout), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();

    // Basic load-use hazard: exactly one bubble
    hz.ID_rs = 5'd3; hz.EX_rt = 5'd3; hz.EX_Mem_rd = 1'b1;
    #1 chk("lu.ctl", 32'(dut_ctl()), 32'b110001);
    step("lu");
    clear_inputs();
    #1;
    chk("lu.after.ctl", 32'(dut_ctl()),    32'd0);
    chk("lu.stall_cnt", 32'(hz.stall_cnt), 32'd1);
    step("lu.after");

    // Loads targeting r0 and rt reads without uses_rt do not stall
    hz.EX_Mem_rd = 1'b1; hz.EX_rt = 5'd0; hz.ID_rs = 5'd0; hz.ID_rt = 5'd0; hz.ID_uses_rt = 1'b1;
    #1 chk("lu.r0.ctl", 32'(dut_ctl()), 32'd0);
    step("lu.r0");
    hz.EX_rt = 5'd5; hz.ID_rt = 5'd5; hz.ID_rs = 5'd1; hz.ID_uses_rt = 1'b0;
    #1 chk("lu.nort.ctl", 32'(dut_ctl()), 32'd0);
    step("lu.nort");
    hz.ID_uses_rt = 1'b1;
    #1 chk("lu.rt.ctl", 32'(dut_ctl()), 32'b110001);
    step("lu.rt");
    clear_inputs();

    // Branch outranks load-use and jump
    hz.EX_Branch_taken = 1'b1; hz.ID_rs = 5'd3; hz.EX_rt = 5'd3; hz.EX_Mem_rd = 1'b1; hz.ID_Jump = 1'b1;
    f0 = m_flush;
    #1 chk("prio.ctl", 32'(dut_ctl()), 32'b000011);
    step("prio");
    hz.EX_Branch_taken = 1'b0; hz.EX_Mem_rd = 1'b0;
    #1 chk("jump.ctl", 32'(dut_ctl()), 32'b000010);
    chk("prio.flush_cnt", 32'(hz.flush_cnt), f0 + 1);
    step("jump");
    clear_inputs();

    // Branch held while memory is busy for 4 cycles; the flush follows once back in RUN
    s0 = m_stall;
    hz.EX_Branch_taken = 1'b1;
    hz.MEM_busy        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("mbr.busy.ctl", 32'(dut_ctl()), 32'b111100);
      step("mbr.busy");
    end
    hz.MEM_busy = 1'b0;
    #1 chk("mbr.drain.ctl", 32'(dut_ctl()), 32'b111100);
    step("mbr.drain");
    #1 chk("mbr.flush.ctl", 32'(dut_ctl()), 32'b000011);
    chk("mbr.stall_cnt", 32'(hz.stall_cnt), s0 + 5);
    step("mbr.flush");
    clear_inputs();

    // Watchdog: busy held past TMO MEM_WAIT cycles
    s0 = m_stall;
    hz.MEM_busy = 1'b1;
    for (int i = 0; i < int'(TMO) + 1; i++) step("wd");
    #1;
    chk("wd.timeout",   32'(hz.mem_timeout), 32'd1);
    chk("wd.stall_cnt", 32'(hz.stall_cnt),   s0 + TMO + 1);
    hz.MEM_busy = 1'b0;
    #1 chk("wd.run.ctl", 32'(dut_ctl()), 32'd0);
    step("wd.run");
    step("wd.idle");
    #1 chk("wd.sticky", 32'(hz.mem_timeout), 32'd1);

    // Random traffic; small register range so hazards occur often
    for (int n = 0; n < 600; n++) begin
      hz.ID_rs           = 5'($urandom_range(0, 3));
      hz.ID_rt           = 5'($urandom_range(0, 3));
      hz.EX_rt           = 5'($urandom_range(0, 3));
      hz.ID_uses_rt      = 1'($urandom_range(0, 1));
      hz.EX_Mem_rd       = 1'($urandom_range(0, 1));
      hz.EX_Branch_taken = ($urandom_range(0, 5) == 0);
      hz.ID_Jump         = ($urandom_range(0, 3) == 0);
      hz.MEM_busy        = ($urandom_range(0, 3) == 0);
      step("rnd");
    end
    clear_inputs();
    step("rnd.end");

    // Reset in the middle of MEM_WAIT with a branch held
    hz.MEM_busy = 1'b1; hz.EX_Branch_taken = 1'b1;
    repeat (3) step("mrst.wait");
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("mrst.ctl",       32'(dut_ctl()),      32'd0);
    chk("mrst.stall_cnt", 32'(hz.stall_cnt),   32'd0);
    chk("mrst.flush_cnt", 32'(hz.flush_cnt),   32'd0);
    chk("mrst.timeout",   32'(hz.mem_timeout), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    hz.MEM_busy = 1'b0;
    #1 chk("mrst.run.ctl", 32'(dut_ctl()), 32'b000011);
    step("mrst.run");
    clear_inputs();

    // Counter saturation driven by a held load-use hazard (it stalls and flushes every cycle)
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    hz.ID_rs = 5'd7; hz.EX_rt = 5'd7; hz.EX_Mem_rd = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    m_stall = 65534;
    m_flush = 65534;
    #1;
    chk("sat.pre.stall", 32'(hz.stall_cnt), 32'hFFFE);
    chk("sat.pre.flush", 32'(hz.flush_cnt), 32'hFFFE);
    repeat (3) step("sat");
    #1;
    chk("sat.stall", 32'(hz.stall_cnt), 32'hFFFF);
    chk("sat.flush", 32'(hz.flush_cnt), 32'hFFFF);
    step("sat.hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
